io_input_bank: RTL and testbench
================================

IO_INPUT_BANK -- requirements
Module: io_input_bank

Interface
REQ-001 Parameter N_PORTS, default 4: number of input channels, range 1..8.
REQ-002 Parameter PORT_W, default 5: width of each input channel, range 1..32.
REQ-003 Parameter DB_CYCLES, default 4: debounce stability count, range 1..255.
REQ-004 Parameter BASE_SEL, default 6'b110000: addr[7:2] value of word 0.
REQ-005 io_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 addr  input  32  byte address; only addr[7:2] is decoded.
REQ-008 rd_en  input  1  read strobe; qualifies the read-to-clear side effect only.
REQ-009 in_ports  input  N_PORTS*PORT_W  raw asynchronous inputs; channel i is bits [i*PORT_W +: PORT_W].
REQ-010 io_read_data  output  32  read data, combinational from addr and internal registers.
REQ-011 irq  output  1  level interrupt, high while any change-status bit is set.

Function
REQ-012 Each channel SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each channel SHALL hold a stable register and an 8-bit debounce counter cnt.
REQ-014 When s2 equals stable, cnt SHALL be cleared to 0 on that edge.
REQ-015 When s2 differs from stable and cnt < DB_CYCLES-1, cnt SHALL increment by 1.
REQ-016 When s2 differs from stable and cnt == DB_CYCLES-1, stable SHALL load s2, cnt SHALL clear, and status[i] SHALL set.
REQ-017 A step on a channel held constant SHALL appear in stable after exactly DB_CYCLES+2 rising edges.
REQ-018 A glitch that returns to the stable value before the count completes SHALL restart cnt at 0 and leave stable and status unchanged.
REQ-019 Word offset k = addr[7:2] - BASE_SEL; for k in 0..N_PORTS-1, io_read_data SHALL be {zeros, stable of channel k}.
REQ-020 For k == N_PORTS, io_read_data SHALL be {zeros, status[N_PORTS-1:0]}.
REQ-021 For k == N_PORTS+1, io_read_data SHALL be the constant {16'h0, N_PORTS[7:0], PORT_W[7:0]}, the identification word.
REQ-022 Any other addr[7:2] value SHALL return 32'h0; no latch or hold of the previous value.
REQ-023 On a rising edge with rd_en=1 and k == N_PORTS, status SHALL clear; the read data in that cycle SHALL be the pre-clear value.
REQ-024 If a status bit sets on the same edge as a read-to-clear, the set SHALL win for that bit; other bits clear.
REQ-025 Reads of the data words or the ID word SHALL have no side effect; rd_en on them is ignored.
REQ-026 irq SHALL equal the OR of all status bits, registered state only, with no combinational path from addr or rd_en.

Reset
REQ-027 resetn low SHALL immediately clear s1, s2, stable, cnt and status for all channels, independent of io_clk.
REQ-028 While resetn is low, irq SHALL be 0 and the data words SHALL read 0.
REQ-029 After resetn deasserts, an input held nonzero through reset SHALL be accepted as a change after DB_CYCLES+2 edges and SHALL set status.
REQ-030 Reset asserted during a debounce count SHALL abort the count with no status set.

Verification
REQ-031 Default parameters; channel 1 steps from 0 to 5'h13 -> stable is unchanged at edge 5 and reads 32'h13 at offset 1 after edge 6; status = 4'b0010; irq = 1.
REQ-032 Channel 0 pulses to 5'h1F for 3 cycles, then returns to 0 -> offset 0 stays 0; status stays 0; irq stays 0.
REQ-033 status = 4'b0011; read offset 4 with rd_en=1 -> data 32'h3 in that cycle; status = 0 and irq = 0 after the edge.
REQ-034 Channel 2 debounce completes on the same edge as an offset-4 read-clear of status 4'b0001 -> status = 4'b0100 after the edge; irq stays 1.
REQ-035 addr[7:2] = 6'b110101 -> io_read_data = 32'h00000405; addr[7:2] = 6'b111111 -> 32'h0.
REQ-036 resetn pulsed low mid-count on channel 3 -> stable, cnt and status are 0 immediately; channel 3 re-debounces with the full DB_CYCLES+2 latency after release.

Source files
------------

// File: rtl/io_input_bank.sv
// ---------------------------------------------------------------------------
// io_input_bank
//   Bank of N_PORTS debounced input channels. Each channel is synchronised
//   through two flops. It then has to hold a new value for DB_CYCLES
//   consecutive cycles before that value is accepted into the channel's stable
//   register. Each accepted change sets a sticky status bit. The status bits
//   drive a level interrupt and are cleared by reading the status word.
//
// Parameters
//   N_PORTS   number of input channels (1..8)
//   PORT_W    width of each channel (1..32)
//   DB_CYCLES debounce stability count (1..255)
//   BASE_SEL  addr[7:2] value of word 0
//
// Ports
//   io_clk        single clock, rising edge
//   resetn        asynchronous active-low reset
//   addr          byte address, only addr[7:2] decoded
//   rd_en         read strobe, qualifies read-to-clear of the status word
//   in_ports      raw asynchronous inputs, channel i at [i*PORT_W +: PORT_W]
//   io_read_data  combinational read data
//   irq           high while any status bit is set
//
// Word map (k = addr[7:2] - BASE_SEL)
//   0..N_PORTS-1  stable value of channel k
//   N_PORTS       status bits (read-to-clear when rd_en)
//   N_PORTS+1     ID word {16'h0, N_PORTS, PORT_W}
//   others        zero
// ---------------------------------------------------------------------------
module io_input_bank #(
  parameter int          N_PORTS   = 4,
  parameter int          PORT_W    = 5,
  parameter int          DB_CYCLES = 4,
  parameter logic [5:0]  BASE_SEL  = 6'b110000
) (
  input  logic                        io_clk,
  input  logic                        resetn,
  input  logic [31:0]                 addr,
  input  logic                        rd_en,
  input  logic [N_PORTS*PORT_W-1:0]   in_ports,
  output logic [31:0]                 io_read_data,
  output logic                        irq
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [PORT_W-1:0]  r_s1     [N_PORTS];
  logic [PORT_W-1:0]  r_s2     [N_PORTS];
  logic [PORT_W-1:0]  r_stable [N_PORTS];
  logic [7:0]         r_cnt    [N_PORTS];
  logic [N_PORTS-1:0] r_status;

  logic [5:0]         w_k;
  logic               w_clr;
  logic [N_PORTS-1:0] w_set;
  logic               w_unused_addr;

  // Modulo-64 subtraction maps addresses below BASE_SEL to large offsets,
  // which fall into the "return zero" region.
  assign w_k           = addr[7:2] - BASE_SEL;
  assign w_clr         = rd_en && (w_k == 6'(N_PORTS));
  assign w_unused_addr = &{1'b0, addr[31:8], addr[1:0]};

  // A channel completes its debounce when it still differs on the final count.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_set[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_s1[i]     <= '0;
        r_s2[i]     <= '0;
        r_stable[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_status <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_s1[i] <= in_ports[i*PORT_W +: PORT_W];
        r_s2[i] <= r_s1[i];
        if (r_s2[i] == r_stable[i]) begin
          // Any return to the stable value, including a glitch, restarts the count.
          r_cnt[i] <= '0;
        end else if (w_set[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
      // A new event on the same edge as a read-clear is kept, so it is not lost.
      r_status <= (r_status & ~{N_PORTS{w_clr}}) | w_set;
    end
  end

  always_comb begin
    io_read_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_k == 6'(i)) io_read_data[PORT_W-1:0] = r_stable[i];
    end
    if (w_k == 6'(N_PORTS)) io_read_data[N_PORTS-1:0] = r_status;
    if (w_k == 6'(N_PORTS + 1)) io_read_data = {16'h0, 8'(N_PORTS), 8'(PORT_W)};
  end

  assign irq = |r_status;

endmodule

// File: tb/tb_io_input_bank.sv
module tb_io_input_bank;

  logic        io_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr   = '0;
  logic        rd_en  = 1'b0;
  logic [19:0] in_ports = '0;
  logic [31:0] io_read_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_input_bank #(
    .N_PORTS(4), .PORT_W(5), .DB_CYCLES(4), .BASE_SEL(6'b110000)
  ) dut (
    .io_clk(io_clk), .resetn(resetn), .addr(addr), .rd_en(rd_en),
    .in_ports(in_ports), .io_read_data(io_read_data), .irq(irq)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_addr(input int k);
    logic [5:0] sel;
    sel = 6'(48 + k);
    return {24'h0, sel, 2'b00};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input logic [4:0] v);
    in_ports[ch*5 +: 5] = v;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    in_ports = 20'h0;
    tick(2);
    addr = word_addr(0); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL reset_word0: got %h expected %h", io_read_data, 32'h0); end
    addr = word_addr(4); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", io_read_data, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic test_glitch;
    set_ch(0, 5'h1F);
    tick(3);
    set_ch(0, 5'h00);
    tick(10);
    addr = word_addr(0); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL glitch_word0: got %h expected %h", io_read_data, 32'h0); end
    addr = word_addr(4); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h expected %h", io_read_data, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_step;
    set_ch(1, 5'h13);
    tick(5);
    addr = word_addr(1); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL step_edge5: got %h expected %h", io_read_data, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL step_irq_edge5: got %b expected 0", irq); end
    tick(1);
    checks++; if (io_read_data !== 32'h13) begin errors++; $display("FAIL step_edge6: got %h expected %h", io_read_data, 32'h13); end
    addr = word_addr(4); #1;
    checks++; if (io_read_data !== 32'h2) begin errors++; $display("FAIL step_status: got %h expected %h", io_read_data, 32'h2); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL step_irq: got %b expected 1", irq); end
  endtask

  task automatic test_read_clear;
    set_ch(0, 5'h0A);
    tick(6);
    addr = word_addr(0); #1;
    checks++; if (io_read_data !== 32'hA) begin errors++; $display("FAIL rc_word0: got %h expected %h", io_read_data, 32'hA); end
    // rd_en on a data word and on the ID word must not disturb status
    rd_en = 1'b1; addr = word_addr(1);
    tick(1);
    addr = word_addr(5);
    tick(1);
    rd_en = 1'b0; addr = word_addr(4); #1;
    checks++; if (io_read_data !== 32'h3) begin errors++; $display("FAIL rc_no_side_effect: got %h expected %h", io_read_data, 32'h3); end
    rd_en = 1'b1; #1;
    checks++; if (io_read_data !== 32'h3) begin errors++; $display("FAIL rc_preclear: got %h expected %h", io_read_data, 32'h3); end
    tick(1);
    rd_en = 1'b0; #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL rc_cleared: got %h expected %h", io_read_data, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rc_irq: got %b expected 0", irq); end
    addr = word_addr(1); #1;
    checks++; if (io_read_data !== 32'h13) begin errors++; $display("FAIL rc_word1_kept: got %h expected %h", io_read_data, 32'h13); end
  endtask

  task automatic test_same_edge;
    set_ch(0, 5'h00);
    tick(6);
    addr = word_addr(4); #1;
    checks++; if (io_read_data !== 32'h1) begin errors++; $display("FAIL se_status_pre: got %h expected %h", io_read_data, 32'h1); end
    set_ch(2, 5'h07);
    tick(5);
    rd_en = 1'b1; #1;
    checks++; if (io_read_data !== 32'h1) begin errors++; $display("FAIL se_read_data: got %h expected %h", io_read_data, 32'h1); end
    tick(1);
    rd_en = 1'b0; #1;
    checks++; if (io_read_data !== 32'h4) begin errors++; $display("FAIL se_status_post: got %h expected %h", io_read_data, 32'h4); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL se_irq: got %b expected 1", irq); end
    addr = word_addr(2); #1;
    checks++; if (io_read_data !== 32'h7) begin errors++; $display("FAIL se_word2: got %h expected %h", io_read_data, 32'h7); end
  endtask

  task automatic test_decode;
    addr = {24'h0, 6'b110101, 2'b00}; #1;
    checks++; if (io_read_data !== 32'h00000405) begin errors++; $display("FAIL id_word: got %h expected %h", io_read_data, 32'h405); end
    addr = {24'hFFFFFF, 6'b110101, 2'b11}; #1;
    checks++; if (io_read_data !== 32'h00000405) begin errors++; $display("FAIL id_upper_bits: got %h expected %h", io_read_data, 32'h405); end
    addr = {24'h0, 6'b111111, 2'b00}; #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL unmapped_3f: got %h expected %h", io_read_data, 32'h0); end
    addr = word_addr(6); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL unmapped_k6: got %h expected %h", io_read_data, 32'h0); end
    addr = {24'h0, 6'b000010, 2'b00}; #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL unmapped_low: got %h expected %h", io_read_data, 32'h0); end
  endtask

  task automatic test_reset_mid;
    // clear pending status first
    addr = word_addr(4); rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    set_ch(3, 5'h15);
    tick(4);
    resetn = 1'b0; #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rm_irq: got %b expected 0", irq); end
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL rm_status: got %h expected %h", io_read_data, 32'h0); end
    addr = word_addr(2); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL rm_word2: got %h expected %h", io_read_data, 32'h0); end
    resetn = 1'b1;
    tick(5);
    addr = word_addr(3); #1;
    checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL rm_edge5: got %h expected %h", io_read_data, 32'h0); end
    tick(1);
    checks++; if (io_read_data !== 32'h15) begin errors++; $display("FAIL rm_edge6: got %h expected %h", io_read_data, 32'h15); end
    addr = word_addr(4); #1;
    // channels 1, 2 and 3 held nonzero through reset are all re-accepted
    checks++; if (io_read_data !== 32'hE) begin errors++; $display("FAIL rm_status_post: got %h expected %h", io_read_data, 32'hE); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rm_irq_post: got %b expected 1", irq); end
    addr = word_addr(1); #1;
    checks++; if (io_read_data !== 32'h13) begin errors++; $display("FAIL rm_word1: got %h expected %h", io_read_data, 32'h13); end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_step;
    test_read_clear;
    test_same_edge;
    test_decode;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
